obi_dram_bridge: RTL

//  OBI slave to DRAM-controller native command/response bridge, replacing the

---
 rtl/obi_dram_bridge.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/obi_dram_bridge.sv
// OBI slave to DRAM-controller command/response bridge.
// Keeps up to MAX_OUTSTANDING in-order transactions in flight. Accesses outside
// the address window get an error response and never reach the controller.
module obi_dram_bridge #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h4000_0000,
    parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES      = 32'h1000_0000,
    parameter int                    MEM_AW          = $clog2(SIZE_BYTES)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               obi_req_i,
    input  logic [ADDR_WIDTH-1:0]              obi_addr_i,
    input  logic                               obi_we_i,
    input  logic [DATA_WIDTH/8-1:0]            obi_be_i,
    input  logic [DATA_WIDTH-1:0]              obi_wdata_i,
    output logic                               obi_gnt_o,
    output logic                               obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]              obi_rdata_o,
    output logic                               obi_err_o,
    output logic                               mem_cmd_valid_o,
    input  logic                               mem_cmd_ready_i,
    output logic [MEM_AW-1:0]                  mem_cmd_addr_o,
    output logic                               mem_cmd_we_o,
    output logic [DATA_WIDTH/8-1:0]            mem_cmd_be_o,
    output logic [DATA_WIDTH-1:0]              mem_cmd_wdata_o,
    input  logic                               mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]              mem_rsp_rdata_i,
    input  logic                               mem_rsp_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                               protocol_err_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0]         MAXC     = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0]         PTR_LAST = PW'(MAX_OUTSTANDING - 1);
    localparam logic [ADDR_WIDTH:0]   WIN_LO   = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0]   WIN_HI   = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};

    logic                    r_cmd_valid;
    logic [MEM_AW-1:0]       r_cmd_addr;
    logic                    r_cmd_we;
    logic [DATA_WIDTH/8-1:0] r_cmd_be;
    logic [DATA_WIDTH-1:0]   r_cmd_wdata;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic                    r_lerr;
    logic [CW-1:0]           r_cnt;
    logic                    r_proto;
    logic [MAX_OUTSTANDING-1:0] r_we_q;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;

    logic              w_in_win;
    logic              w_cmd_free;
    logic              w_gnt_win;
    logic              w_gnt_oow;
    logic              w_gnt;
    logic              w_rsp_ok;
    logic              w_head_we;
    logic [MEM_AW-1:0] w_off;

    // Window compare one bit wider so a window ending at the top of the space works.
    assign w_in_win   = ({1'b0, obi_addr_i} >= WIN_LO) && ({1'b0, obi_addr_i} < WIN_HI);
    assign w_cmd_free = !r_cmd_valid || mem_cmd_ready_i;
    // Out-of-window requests wait for a fully drained bridge so responses stay in order.
    assign w_gnt_win  = !rst_i && obi_req_i && !r_lerr && w_in_win && w_cmd_free && (r_cnt < MAXC);
    assign w_gnt_oow  = !rst_i && obi_req_i && !r_lerr && !w_in_win && (r_cnt == '0) && !r_cmd_valid;
    assign w_gnt      = w_gnt_win || w_gnt_oow;
    // Offset is taken modulo the window size, so only the low bits need subtracting.
    assign w_off      = obi_addr_i[MEM_AW-1:0] - BASE_ADDR[MEM_AW-1:0];
    // While the local error response is pending only that transaction is counted,
    // so any controller response then is spurious.
    assign w_rsp_ok   = mem_rsp_valid_i && (r_cnt != '0) && !r_lerr;
    assign w_head_we  = r_we_q[r_rd_ptr];

    assign obi_gnt_o       = w_gnt;
    assign obi_rvalid_o    = r_rvalid;
    assign obi_rdata_o     = r_rdata;
    assign obi_err_o       = r_err;
    assign mem_cmd_valid_o = r_cmd_valid;
    assign mem_cmd_addr_o  = r_cmd_addr;
    assign mem_cmd_we_o    = r_cmd_we;
    assign mem_cmd_be_o    = r_cmd_be;
    assign mem_cmd_wdata_o = r_cmd_wdata;
    assign outstanding_o   = r_cnt;
    assign protocol_err_o  = r_proto;

    // Command register: load on in-window grant, hold until the controller accepts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cmd_valid <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_we    <= 1'b0;
            r_cmd_be    <= '0;
            r_cmd_wdata <= '0;
        end else if (w_gnt_win) begin
            r_cmd_valid <= 1'b1;
            r_cmd_addr  <= w_off;
            r_cmd_we    <= obi_we_i;
            r_cmd_be    <= obi_be_i;
            r_cmd_wdata <= obi_wdata_i;
        end else if (mem_cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
        end
    end

    // Per-transaction write flag queue so write responses return zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we_q   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_gnt_win) begin
                r_we_q[r_wr_ptr] <= obi_we_i;
                r_wr_ptr         <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rsp_ok) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Response register: local window error or controller response, one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_lerr   <= 1'b0;
            r_proto  <= 1'b0;
        end else begin
            r_lerr   <= w_gnt_oow;
            r_rvalid <= w_gnt_oow || w_rsp_ok;
            r_err    <= w_gnt_oow || (w_rsp_ok && mem_rsp_err_i);
            r_rdata  <= (w_rsp_ok && !w_head_we && !mem_rsp_err_i) ? mem_rsp_rdata_i : '0;
            if (mem_rsp_valid_i && !w_rsp_ok) begin
                r_proto <= 1'b1;
            end
        end
    end

    // Outstanding count: +1 per grant, -1 per delivered response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_gnt && !r_rvalid) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_gnt && r_rvalid) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule
